// File: rtl/seq_num_field_emitter_if.sv
// Byte-stream link from the MsgSeqNum field emitter to the message assembler.
// master drives data/valid/last/field_len and samples ready; slave is the reverse.
interface seq_num_field_emitter_if;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       out_last_o;
    logic [4:0] field_len_o;

    modport master (
        output out_data_o,
        output out_valid_o,
        output out_last_o,
        output field_len_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        input  out_last_o,
        input  field_len_o,
        output out_ready_i
    );
endinterface

// File: rtl/seq_num_field_emitter.sv
// Emits the FIX MsgSeqNum field "34=<digits><SOH>" one byte per accepted beat.
// Ports: clk, rst (async active-low), seq_valid_i/seq_ascii_i/seq_width_i capture
// bus, stream (byte stream master), busy_o, err_o (rejected-capture pulse).
module seq_num_field_emitter #(
    parameter int         MAX_SIZE   = 80,
    parameter int         MAX_DIGITS = 10,
    parameter logic [7:0] SOH        = 8'h01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seq_valid_i,
    input  logic [MAX_SIZE-1:0]   seq_ascii_i,
    input  logic [3:0]            seq_width_i,
    seq_num_field_emitter_if.master stream,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

    typedef enum logic [2:0] {
        IDLE, TAG3, TAG4, EQ, DIG, DELIM
    } state_t;

    state_t                state, nxt;
    logic [3:0]            idx, nidx;
    logic [MAX_SIZE-1:0]   act_ascii, nact_ascii;
    logic [3:0]            act_width, nact_width;
    logic [MAX_SIZE-1:0]   pend_ascii, npend_ascii;
    logic [3:0]            pend_width, npend_width;
    logic                  pend_full, npend_full;
    logic                  nerr;
    logic [7:0]            data_q, data_d;
    logic                  last_q, last_d;
    logic [4:0]            len_q, len_d;
    logic                  legal, cap, accept;

    always_comb begin
        legal = (seq_width_i != 4'd0) && (seq_width_i <= MAXD);
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (4'(k) < seq_width_i) begin
                if (seq_ascii_i[8*k +: 8] < 8'h30 ||
                    seq_ascii_i[8*k +: 8] > 8'h39) begin
                    legal = 1'b0;
                end
            end
        end
    end

    assign cap    = seq_valid_i && legal;
    assign accept = (state != IDLE) && stream.out_ready_i;

    always_comb begin
        nxt         = state;
        nidx        = idx;
        nact_ascii  = act_ascii;
        nact_width  = act_width;
        npend_ascii = pend_ascii;
        npend_width = pend_width;
        npend_full  = pend_full;
        nerr        = seq_valid_i && !legal;

        unique case (state)
            IDLE: begin
                if (cap) begin
                    nact_ascii = seq_ascii_i;
                    nact_width = seq_width_i;
                    nidx       = 4'd0;
                    nxt        = TAG3;
                end
            end
            TAG3: if (accept) nxt = TAG4;
            TAG4: if (accept) nxt = EQ;
            EQ: begin
                if (accept) begin
                    nxt  = DIG;
                    nidx = 4'd0;
                end
            end
            DIG: begin
                if (accept) begin
                    if (idx == act_width - 4'd1) nxt = DELIM;
                    else nidx = idx + 4'd1;
                end
            end
            DELIM: begin
                if (accept) begin
                    nidx = 4'd0;
                    if (pend_full) begin
                        nact_ascii = pend_ascii;
                        nact_width = pend_width;
                        npend_full = 1'b0;
                        nxt        = TAG3;
                    end else if (cap) begin
                        // Capture coinciding with the final beat goes straight
                        // to active so the next field starts without a bubble.
                        nact_ascii = seq_ascii_i;
                        nact_width = seq_width_i;
                        nxt        = TAG3;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase

        if (cap && state != IDLE) begin
            if (pend_full) begin
                nerr = 1'b1;
            end else if (!(state == DELIM && accept)) begin
                npend_ascii = seq_ascii_i;
                npend_width = seq_width_i;
                npend_full  = 1'b1;
            end
        end

        // Outputs are computed from the next state and registered.
        unique case (nxt)
            IDLE:    data_d = 8'h00;
            TAG3:    data_d = 8'h33;
            TAG4:    data_d = 8'h34;
            EQ:      data_d = 8'h3D;
            DIG:     data_d = nact_ascii[{nidx, 3'b000} +: 8];
            DELIM:   data_d = SOH;
            default: data_d = 8'h00;
        endcase
        last_d = (nxt == DELIM);
        len_d  = (nxt == IDLE) ? 5'd0 : ({1'b0, nact_width} + 5'd4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            act_ascii  <= '0;
            act_width  <= 4'd0;
            pend_ascii <= '0;
            pend_width <= 4'd0;
            pend_full  <= 1'b0;
            err_o      <= 1'b0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            len_q      <= 5'd0;
        end else begin
            state      <= nxt;
            idx        <= nidx;
            act_ascii  <= nact_ascii;
            act_width  <= nact_width;
            pend_ascii <= npend_ascii;
            pend_width <= npend_width;
            pend_full  <= npend_full;
            err_o      <= nerr;
            data_q     <= data_d;
            last_q     <= last_d;
            len_q      <= len_d;
        end
    end

    assign stream.out_data_o  = data_q;
    assign stream.out_valid_o = (state != IDLE);
    assign stream.out_last_o  = last_q;
    assign stream.field_len_o = len_q;
    assign busy_o             = (state != IDLE) | pend_full;
endmodule

// File: tb/tb_seq_num_field_emitter.sv
// Self-checking bench for seq_num_field_emitter: directed scenarios plus
// randomized traffic compared against a field-queue reference model.
module tb_seq_num_field_emitter;
    logic        clk = 1'b0;
    logic        rst;
    logic        seq_valid_i;
    logic [79:0] seq_ascii_i;
    logic [3:0]  seq_width_i;
    logic        busy_o;
    logic        err_o;

    seq_num_field_emitter_if sif();

    seq_num_field_emitter dut (
        .clk         (clk),
        .rst         (rst),
        .seq_valid_i (seq_valid_i),
        .seq_ascii_i (seq_ascii_i),
        .seq_width_i (seq_width_i),
        .stream      (sif),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of whole fields in the block (at most two).
    typedef struct {
        logic [7:0] b [14];
        int         len;
    } fld_t;

    fld_t fq[$];
    int   pos = 0;
    bit   err_exp = 0;

    function automatic bit legal(input logic [79:0] a, input logic [3:0] w);
        if (w < 1 || w > 10) return 0;
        for (int k = 0; k < int'(w); k++)
            if (a[8*k +: 8] < 8'h30 || a[8*k +: 8] > 8'h39) return 0;
        return 1;
    endfunction

    function automatic fld_t mkfld(input logic [79:0] a, input logic [3:0] w);
        fld_t f;
        for (int k = 0; k < 14; k++) f.b[k] = 8'h00;
        f.b[0] = 8'h33;
        f.b[1] = 8'h34;
        f.b[2] = 8'h3D;
        for (int k = 0; k < int'(w); k++) f.b[3+k] = a[8*k +: 8];
        f.b[3+int'(w)] = 8'h01;
        f.len = int'(w) + 4;
        return f;
    endfunction

    function automatic logic [79:0] from_str(input string s);
        logic [79:0] a = '0;
        for (int k = 0; k < s.len(); k++) a[8*k +: 8] = s[k];
        return a;
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model, return at
    // the next negedge with DUT outputs settled.
    task automatic drive(input bit v, input logic [79:0] a,
                         input logic [3:0] w, input bit r);
        int sz;
        bit acc;
        bit e;
        seq_valid_i     = v;
        seq_ascii_i     = a;
        seq_width_i     = w;
        sif.out_ready_i = r;
        sz  = fq.size();
        acc = (sz > 0) && r;
        e   = 0;
        if (v) begin
            if (!legal(a, w) || sz >= 2) e = 1;
            else fq.push_back(mkfld(a, w));
        end
        if (acc) begin
            pos++;
            if (pos == fq[0].len) begin
                fq.delete(0);
                pos = 0;
            end
        end
        err_exp = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst             = 1'b0;
        seq_valid_i     = 1'b0;
        seq_ascii_i     = '0;
        seq_width_i     = 4'd0;
        sif.out_ready_i = 1'b0;
        #12;
        checks++;
        if ({sif.out_data_o, sif.out_valid_o, sif.out_last_o,
             sif.field_len_o, busy_o, err_o} !== 17'd0)
            begin failures++; $display("FAIL reset_outputs got=%h exp=0",
                {sif.out_data_o, sif.out_valid_o, sif.out_last_o,
                 sif.field_len_o, busy_o, err_o}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] exp [5];
        exp = '{8'h33, 8'h34, 8'h3D, 8'h37, 8'h01};
        drive(1, {72'h0, 8'h37}, 4'd1, 1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== exp[i])
                begin failures++; $display("FAIL single_data i=%0d got=%h/%b exp=%h",
                    i, sif.out_data_o, sif.out_valid_o, exp[i]); end
            checks++;
            if (sif.out_last_o !== (i == 4))
                begin failures++; $display("FAIL single_last i=%0d got=%b", i, sif.out_last_o); end
            checks++;
            if (sif.field_len_o !== 5'd5 || busy_o !== 1'b1)
                begin failures++; $display("FAIL single_len i=%0d got=%0d busy=%b exp=5/1",
                    i, sif.field_len_o, busy_o); end
            drive(0, '0, 4'd0, 1);
        end
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL single_done valid=%b busy=%b exp=0/0",
                sif.out_valid_o, busy_o); end
    endtask

    task automatic test_width10_toggle;
        fld_t        f;
        logic [79:0] a;
        int          beat = 0;
        bit          r;
        a = from_str("4294967295");
        f = mkfld(a, 4'd10);
        drive(1, a, 4'd10, 1);
        for (int cyc = 0; cyc < 40 && beat < 14; cyc++) begin
            checks++;
            if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== f.b[beat] ||
                sif.field_len_o !== 5'd14)
                begin failures++; $display("FAIL w10_beat cyc=%0d beat=%0d got=%h/%b/%0d exp=%h/1/14",
                    cyc, beat, sif.out_data_o, sif.out_valid_o, sif.field_len_o, f.b[beat]); end
            r = (cyc % 2 == 0);
            drive(0, '0, 4'd0, r);
            if (r) beat++;
        end
        checks++;
        if (beat != 14 || sif.out_valid_o !== 1'b0)
            begin failures++; $display("FAIL w10_count got=%0d valid=%b exp=14/0",
                beat, sif.out_valid_o); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [13];
        exp = '{8'h33, 8'h34, 8'h3D, 8'h39, 8'h38, 8'h37, 8'h01,
                8'h33, 8'h34, 8'h3D, 8'h31, 8'h32, 8'h01};
        drive(1, from_str("987"), 4'd3, 1);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== exp[i])
                begin failures++; $display("FAIL b2b_data i=%0d got=%h/%b exp=%h",
                    i, sif.out_data_o, sif.out_valid_o, exp[i]); end
            drive(i == 3, from_str("12"), 4'd2, 1);
        end
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL b2b_done valid=%b busy=%b exp=0/0",
                sif.out_valid_o, busy_o); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp [13];
        exp = '{8'h33, 8'h34, 8'h3D, 8'h39, 8'h38, 8'h37, 8'h01,
                8'h33, 8'h34, 8'h3D, 8'h31, 8'h32, 8'h01};
        drive(1, from_str("987"), 4'd3, 1);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== exp[i])
                begin failures++; $display("FAIL ovf_data i=%0d got=%h/%b exp=%h",
                    i, sif.out_data_o, sif.out_valid_o, exp[i]); end
            if (i >= 4 && i <= 6) begin
                checks++;
                if (err_o !== (i == 5))
                    begin failures++; $display("FAIL ovf_err i=%0d got=%b exp=%b",
                        i, err_o, (i == 5)); end
            end
            if (i == 3) drive(1, from_str("12"), 4'd2, 1);
            else if (i == 4) drive(1, from_str("55"), 4'd2, 1);
            else drive(0, '0, 4'd0, 1);
        end
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL ovf_done valid=%b busy=%b exp=0/0",
                sif.out_valid_o, busy_o); end
    endtask

    task automatic test_illegal;
        logic [79:0] a [3];
        logic [3:0]  w [3];
        a[0] = from_str("5");           w[0] = 4'd0;
        a[1] = from_str("1234567890");  w[1] = 4'd11;
        a[2] = {64'h0, 8'h41, 8'h31};   w[2] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            drive(1, a[i], w[i], 1);
            checks++;
            if (err_o !== 1'b1 || sif.out_valid_o !== 1'b0 || busy_o !== 1'b0)
                begin failures++; $display("FAIL illegal case=%0d err=%b valid=%b busy=%b exp=1/0/0",
                    i, err_o, sif.out_valid_o, busy_o); end
            drive(0, '0, 4'd0, 1);
            checks++;
            if (err_o !== 1'b0 || sif.out_valid_o !== 1'b0)
                begin failures++; $display("FAIL illegal_after case=%0d err=%b valid=%b exp=0/0",
                    i, err_o, sif.out_valid_o); end
        end
    endtask

    task automatic test_reset_mid_field;
        drive(1, from_str("12345"), 4'd5, 1);
        for (int i = 0; i < 3; i++) drive(0, '0, 4'd0, 1);
        checks++;
        if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== 8'h31)
            begin failures++; $display("FAIL rstmid_pre got=%h/%b exp=31/1",
                sif.out_data_o, sif.out_valid_o); end
        #2 rst = 1'b0;
        #1;
        fq.delete();
        pos = 0;
        err_exp = 0;
        checks++;
        if ({sif.out_data_o, sif.out_valid_o, sif.out_last_o,
             sif.field_len_o, busy_o, err_o} !== 17'd0)
            begin failures++; $display("FAIL rstmid_zero got=%h exp=0",
                {sif.out_data_o, sif.out_valid_o, sif.out_last_o,
                 sif.field_len_o, busy_o, err_o}); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 4'd0, 1);
            checks++;
            if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0)
                begin failures++; $display("FAIL rstmid_after i=%0d valid=%b busy=%b exp=0/0",
                    i, sif.out_valid_o, busy_o); end
        end
    endtask

    task automatic test_random;
        logic [79:0] a;
        logic [3:0]  w;
        bit          v;
        bit          exp_valid;
        int          mode;
        int          k;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_valid = (fq.size() > 0);
            checks++;
            if (sif.out_valid_o !== exp_valid || busy_o !== exp_valid ||
                err_o !== err_exp)
                begin failures++; $display("FAIL rnd_ctrl cyc=%0d valid=%b busy=%b err=%b exp=%b/%b/%b",
                    cyc, sif.out_valid_o, busy_o, err_o, exp_valid, exp_valid, err_exp); end
            if (exp_valid) begin
                checks++;
                if (sif.out_data_o !== fq[0].b[pos] ||
                    sif.out_last_o !== (pos == fq[0].len - 1) ||
                    sif.field_len_o !== 5'(fq[0].len))
                    begin failures++; $display("FAIL rnd_data cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                        cyc, sif.out_data_o, sif.out_last_o, sif.field_len_o,
                        fq[0].b[pos], (pos == fq[0].len - 1), fq[0].len); end
            end
            w = 4'($urandom_range(1, 10));
            for (int j = 0; j < 10; j++)
                a[8*j +: 8] = (j < int'(w)) ? 8'(8'h30 + $urandom_range(0, 9))
                                            : 8'($urandom);
            mode = $urandom_range(0, 11);
            if (mode == 0) w = 4'd0;
            else if (mode == 1) w = 4'($urandom_range(11, 15));
            else if (mode == 2) begin
                k = $urandom_range(0, int'(w) - 1);
                a[8*k +: 8] = 8'($urandom_range(8'h3A, 8'hFF));
            end
            v = ($urandom_range(0, 3) == 0);
            drive(v, a, w, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 80 && fq.size() > 0; i++) drive(0, '0, 4'd0, 1);
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0 || fq.size() != 0)
            begin failures++; $display("FAIL rnd_drain valid=%b busy=%b left=%0d exp=0/0/0",
                sif.out_valid_o, busy_o, fq.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_width10_toggle();
        test_back_to_back();
        test_overflow();
        test_illegal();
        test_reset_mid_field();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
